// File: rtl/engine_clause_receiver.sv
// Engine-side clause receiver: FWFT clause FIFO with registered
// backpressure, flush, overflow flag and chosen-UC latch.
module engine_clause_receiver #(
  parameter int LIT_IDX_MAX = 1024,
  parameter int VAR_W       = $clog2(LIT_IDX_MAX) + 1,
  parameter int CLA_LENGTH  = 3,
  parameter int DEPTH       = 8,
  parameter int SKID        = 1,
  localparam int CLW        = CLA_LENGTH * VAR_W,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           grant_in,
  input  logic [CLW-1:0] clause_in,
  output logic           full_out,
  input  logic [VAR_W-1:0] chosen_uc_in,
  input  logic           chosen_uc_valid_in,
  input  logic           flush_in,
  output logic [CLW-1:0] clause_out,
  output logic           clause_valid_out,
  input  logic           clause_ready_in,
  output logic [VAR_W-1:0] uc_out,
  output logic           uc_valid_out,
  output logic [CW-1:0]  count_out,
  output logic           overflow_err_out
);

  logic [CLW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic [VAR_W-1:0] uc_q, uc_d;
  logic             uc_vld_q, uc_vld_d;

  logic push;
  logic pop;
  logic drop;
  logic mem_we;

  // Head of queue is shown straight from storage (first-word fall-through).
  assign clause_valid_out = (count_q != '0);
  assign clause_out       = mem_q[rd_ptr_q];
  assign full_out         = full_q;
  assign count_out        = count_q;
  assign overflow_err_out = ovf_q;
  assign uc_out           = uc_q;
  assign uc_valid_out     = uc_vld_q;

  // FIFO next state; a flush wins over any push or pop in the same cycle.
  always_comb begin
    pop      = clause_valid_out & clause_ready_in;
    push     = grant_in & ((count_q < CW'(DEPTH)) | pop);
    drop     = grant_in & ~push;
    mem_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
    end else begin
      mem_we   = push;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      full_d   = (count_d >= CW'(DEPTH - SKID));
      ovf_d    = ovf_q | drop;
    end
  end

  // Chosen unit clause latch with a one-cycle new-value pulse.
  always_comb begin
    uc_d     = uc_q;
    uc_vld_d = chosen_uc_valid_in;
    if (chosen_uc_valid_in) begin
      uc_d = chosen_uc_in;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      uc_q     <= '0;
      uc_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      uc_q     <= uc_d;
      uc_vld_q <= uc_vld_d;
    end
  end

  // Clause storage; not cleared by reset, occupancy tracks validity.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= clause_in;
    end
  end

endmodule

// File: tb/tb_engine_clause_receiver.sv
// Bench for engine_clause_receiver: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_engine_clause_receiver;

  localparam int VAR_W = 11;
  localparam int CLW   = 33;
  localparam int DEPTH = 8;
  localparam int SKID  = 1;
  localparam int CW    = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             grant_in;
  logic [CLW-1:0]   clause_in;
  logic             full_out;
  logic [VAR_W-1:0] chosen_uc_in;
  logic             chosen_uc_valid_in;
  logic             flush_in;
  logic [CLW-1:0]   clause_out;
  logic             clause_valid_out;
  logic             clause_ready_in;
  logic [VAR_W-1:0] uc_out;
  logic             uc_valid_out;
  logic [CW-1:0]    count_out;
  logic             overflow_err_out;

  int checks = 0;
  int errors = 0;

  logic [CLW-1:0]   m_q[$];
  logic             m_full;
  logic             m_ovf;
  logic [VAR_W-1:0] m_uc;
  logic             m_ucv;

  always #5 clock = ~clock;

  engine_clause_receiver dut (
    .clock              (clock),
    .reset              (reset),
    .grant_in           (grant_in),
    .clause_in          (clause_in),
    .full_out           (full_out),
    .chosen_uc_in       (chosen_uc_in),
    .chosen_uc_valid_in (chosen_uc_valid_in),
    .flush_in           (flush_in),
    .clause_out         (clause_out),
    .clause_valid_out   (clause_valid_out),
    .clause_ready_in    (clause_ready_in),
    .uc_out             (uc_out),
    .uc_valid_out       (uc_valid_out),
    .count_out          (count_out),
    .overflow_err_out   (overflow_err_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("count", 64'(count_out), 64'(m_q.size()));
    chk("valid", 64'(clause_valid_out), 64'(m_q.size() != 0));
    if (m_q.size() != 0)
      chk("head", 64'(clause_out), 64'(m_q[0]));
    chk("full", 64'(full_out), 64'(m_full));
    chk("ovf", 64'(overflow_err_out), 64'(m_ovf));
    chk("uc", 64'(uc_out), 64'(m_uc));
    chk("ucv", 64'(uc_valid_out), 64'(m_ucv));
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cyc(input logic g, input logic [CLW-1:0] c,
                     input logic rdy, input logic fl,
                     input logic uv, input logic [VAR_W-1:0] u,
                     input logic rst);
    logic pop;
    reset              = rst;
    grant_in           = g;
    clause_in          = c;
    clause_ready_in    = rdy;
    flush_in           = fl;
    chosen_uc_valid_in = uv;
    chosen_uc_in       = u;
    if (rst) begin
      m_q.delete();
      m_full = 1'b0;
      m_ovf  = 1'b0;
      m_uc   = '0;
      m_ucv  = 1'b0;
    end else begin
      pop = (m_q.size() != 0) && rdy;
      if (fl) begin
        m_q.delete();
        m_full = 1'b0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (g) begin
          if (m_q.size() < DEPTH) m_q.push_back(c);
          else m_ovf = 1'b1;
        end
        m_full = (m_q.size() >= DEPTH - SKID);
      end
      if (uv) m_uc = u;
      m_ucv = uv;
    end
    @(posedge clock);
    #1;
    chk_model();
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, '0, rdy, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic gnt(input logic [CLW-1:0] c, input logic rdy);
    cyc(1'b1, c, rdy, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rst_cyc();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [63:0] r;
    logic [CLW-1:0] c;
    int n;

    // Reset state
    rst_cyc();
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_full", 64'(full_out), 64'd0);
    chk("rst_uc", 64'(uc_out), 64'd0);

    // Three grants, no ready
    for (int i = 1; i <= 3; i++) gnt(CLW'(i), 1'b0);
    chk("t1_count", 64'(count_out), 64'd3);
    chk("t1_head", 64'(clause_out), 64'd1);
    chk("t1_valid", 64'(clause_valid_out), 64'd1);
    chk("t1_full", 64'(full_out), 64'd0);

    // Fill to threshold, then to DEPTH, then overflow
    rst_cyc();
    for (int i = 1; i <= 6; i++) gnt(CLW'(i), 1'b0);
    chk("t2_full6", 64'(full_out), 64'd0);
    gnt(CLW'(7), 1'b0);
    chk("t2_full7", 64'(full_out), 64'd1);
    gnt(CLW'(8), 1'b0);
    chk("t2_count8", 64'(count_out), 64'd8);
    chk("t2_ovf0", 64'(overflow_err_out), 64'd0);
    gnt(CLW'(100), 1'b0);
    chk("t2_ovf1", 64'(overflow_err_out), 64'd1);
    chk("t2_count9", 64'(count_out), 64'd8);

    // Full with simultaneous push and pop, then drain
    gnt(CLW'(9), 1'b1);
    chk("t3_count", 64'(count_out), 64'd8);
    chk("t3_head", 64'(clause_out), 64'd2);
    for (int i = 2; i <= 9; i++) begin
      chk("t3_drain", 64'(clause_out), 64'(i));
      idle(1'b1);
    end
    chk("t3_empty", 64'(clause_valid_out), 64'd0);
    idle(1'b1);
    chk("t3_empty_rdy", 64'(count_out), 64'd0);

    // Streaming
    rst_cyc();
    for (int i = 0; i < 10; i++) begin
      gnt(CLW'(40 + i), 1'b1);
      chk("t4_count", 64'(count_out), 64'd1);
      chk("t4_head", 64'(clause_out), 64'(40 + i));
      chk("t4_full", 64'(full_out), 64'd0);
    end

    // Flush with concurrent grant
    rst_cyc();
    for (int i = 1; i <= 5; i++) gnt(CLW'(i), 1'b0);
    cyc(1'b1, CLW'(77), 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("t5_count", 64'(count_out), 64'd0);
    chk("t5_valid", 64'(clause_valid_out), 64'd0);
    chk("t5_ovf", 64'(overflow_err_out), 64'd0);
    gnt(CLW'(24), 1'b0);
    chk("t5_head", 64'(clause_out), 64'd24);

    // Unit clause latch
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'b101_1011_1011, 1'b0);
    chk("t6_uc", 64'(uc_out), 64'h5BB);
    chk("t6_ucv", 64'(uc_valid_out), 64'd1);
    idle(1'b0);
    chk("t6_ucv_off", 64'(uc_valid_out), 64'd0);
    chk("t6_uc_hold", 64'(uc_out), 64'h5BB);
    rst_cyc();
    chk("t6_uc_rst", 64'(uc_out), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom};
      c = r[CLW-1:0];
      n = int'($urandom_range(0, 99));
      cyc($urandom_range(0, 99) < 65,
          c,
          $urandom_range(0, 99) < 40,
          n < 3,
          $urandom_range(0, 99) < 20,
          VAR_W'($urandom),
          n == 99);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
